// File: rtl/uart_irq_sched.sv
// UART interrupt scheduler: latches per-source events, picks the highest
// priority pending source and holds the interrupt line until software
// acknowledges it, then waits a programmable holdoff before re-raising.
module uart_irq_sched #(
  parameter int NUM_SRC = 4,
  parameter int HOLD_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_SRC-1:0] en_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [HOLD_W-1:0]  holdoff_i,
  input  logic               ack_i,
  output logic               irq_o,
  output logic [1:0]         id_o,
  output logic [NUM_SRC-1:0] pend_o,
  output logic [NUM_SRC-1:0] ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLD
  } state_t;

  state_t              state_q;
  logic                irq_q;
  logic [1:0]          id_q;
  logic [HOLD_W-1:0]   cnt_q;
  logic [NUM_SRC-1:0]  src_q;
  logic [NUM_SRC-1:0]  pend_q, pend_d;
  logic [NUM_SRC-1:0]  ovf_q, ovf_d;
  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  setVec;
  logic [NUM_SRC-1:0]  clrVec;
  logic [NUM_SRC-1:0]  ackMask;
  logic                ackHit;
  logic [1:0]          prioId;

  // Event detection and pending/overflow next-state; a set in the same
  // cycle as a clear keeps the pending bit but starts overflow fresh.
  always_comb begin
    rise    = src_i & ~src_q;
    setVec  = rise & en_i;
    ackHit  = (state_q == ASSERT) && ack_i;
    ackMask = ackHit ? (NUM_SRC'(1) << id_q) : '0;
    clrVec  = ackMask | ~en_i;
    pend_d  = setVec | (pend_q & ~clrVec);
    ovf_d   = (ovf_q | (setVec & pend_q)) & ~clrVec;
  end

  // Fixed priority encoder: lowest index wins.
  always_comb begin
    prioId = 2'd3;
    casez (pend_q)
      4'b???1: prioId = 2'd0;
      4'b??10: prioId = 2'd1;
      4'b?100: prioId = 2'd2;
      default: prioId = 2'd3;
    endcase
  end

  // Source history and sticky pending/overflow registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_q  <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // Serving FSM with registered irq/id; the served id stays frozen while asserted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      id_q    <= 2'd0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q != '0) begin
            id_q    <= prioId;
            irq_q   <= 1'b1;
            state_q <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack_i) begin
            irq_q <= 1'b0;
            if (holdoff_i == '0) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= holdoff_i;
              state_q <= HOLD;
            end
          end else if (!en_i[id_q]) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          irq_q <= 1'b0;
          if (cnt_q == HOLD_W'(1)) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq_o  = irq_q;
  assign id_o   = id_q;
  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_uart_irq_sched.sv
// Directed bench for uart_irq_sched: each step queues the expected outputs,
// advances one clock and pops the expectation to compare against the DUT.
module tb_uart_irq_sched;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [3:0] en_i;
  logic [3:0] src_i;
  logic [7:0] holdoff_i;
  logic       ack_i;
  logic       irq_o;
  logic [1:0] id_o;
  logic [3:0] pend_o;
  logic [3:0] ovf_o;

  typedef struct {
    string      tag;
    logic       irq;
    logic       chkId;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovf;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  uart_irq_sched #(.NUM_SRC(4), .HOLD_W(8)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (en_i),
    .src_i    (src_i),
    .holdoff_i(holdoff_i),
    .ack_i    (ack_i),
    .irq_o    (irq_o),
    .id_o     (id_o),
    .pend_o   (pend_o),
    .ovf_o    (ovf_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Drive all data inputs at once.
  task automatic applyStimulus(input logic [3:0] src, input logic [3:0] en,
                               input logic ack, input logic [7:0] hold);
    src_i     = src;
    en_i      = en;
    ack_i     = ack;
    holdoff_i = hold;
  endtask

  // Queue an expected DUT output state.
  task automatic pushExp(input string tag, input logic irq, input logic chkId,
                         input logic [1:0] id, input logic [3:0] pend,
                         input logic [3:0] ovf);
    exp_t e;
    e.tag = tag; e.irq = irq; e.chkId = chkId; e.id = id; e.pend = pend; e.ovf = ovf;
    expQ.push_back(e);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = expQ.pop_front();
    checks++;
    assert (irq_o === e.irq) else begin
      errors++;
      $error("[TB] FAIL %s irq observed=%b expected=%b", e.tag, irq_o, e.irq);
    end
    checks++;
    assert (pend_o === e.pend) else begin
      errors++;
      $error("[TB] FAIL %s pend observed=%b expected=%b", e.tag, pend_o, e.pend);
    end
    checks++;
    assert (ovf_o === e.ovf) else begin
      errors++;
      $error("[TB] FAIL %s ovf observed=%b expected=%b", e.tag, ovf_o, e.ovf);
    end
    if (e.chkId) begin
      checks++;
      assert (id_o === e.id) else begin
        errors++;
        $error("[TB] FAIL %s id observed=%0d expected=%0d", e.tag, id_o, e.id);
      end
    end
  endtask

  // Queue, clock, compare.
  task automatic stepChk(input string tag, input logic irq, input logic chkId,
                         input logic [1:0] id, input logic [3:0] pend,
                         input logic [3:0] ovf);
    pushExp(tag, irq, chkId, id, pend, ovf);
    tick();
    checkOutput();
  endtask

  // Directed test sequence.
  initial begin
    rst_n_i = 1'b0;
    applyStimulus(4'h0, 4'hF, 1'b0, 8'd0);
    tick();
    tick();
    pushExp("reset", 1'b0, 1'b1, 2'd0, 4'h0, 4'h0);
    checkOutput();
    rst_n_i = 1'b1;
    stepChk("reset_idle", 1'b0, 1'b1, 2'd0, 4'h0, 4'h0);

    // Single event: two-cycle latency, ack drops irq next cycle
    applyStimulus(4'b0010, 4'hF, 1'b0, 8'd0);
    stepChk("t2_pend", 1'b0, 1'b0, 2'd0, 4'b0010, 4'h0);
    stepChk("t2_irq", 1'b1, 1'b1, 2'd1, 4'b0010, 4'h0);
    applyStimulus(4'b0010, 4'hF, 1'b1, 8'd0);
    stepChk("t2_ack", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t2_held_src", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);

    // Priority and id freeze
    applyStimulus(4'b1100, 4'hF, 1'b0, 8'd0);
    stepChk("t3_pend", 1'b0, 1'b0, 2'd0, 4'b1100, 4'h0);
    stepChk("t3_id2", 1'b1, 1'b1, 2'd2, 4'b1100, 4'h0);
    applyStimulus(4'b1101, 4'hF, 1'b0, 8'd0);
    stepChk("t3_freeze", 1'b1, 1'b1, 2'd2, 4'b1101, 4'h0);
    stepChk("t3_freeze2", 1'b1, 1'b1, 2'd2, 4'b1101, 4'h0);
    applyStimulus(4'b1101, 4'hF, 1'b1, 8'd0);
    stepChk("t3_ack2", 1'b0, 1'b0, 2'd0, 4'b1001, 4'h0);
    applyStimulus(4'b1101, 4'hF, 1'b0, 8'd0);
    stepChk("t3_id0", 1'b1, 1'b1, 2'd0, 4'b1001, 4'h0);
    applyStimulus(4'b1101, 4'hF, 1'b1, 8'd0);
    stepChk("t3_ack0", 1'b0, 1'b0, 2'd0, 4'b1000, 4'h0);
    applyStimulus(4'b1101, 4'hF, 1'b0, 8'd0);
    stepChk("t3_id3", 1'b1, 1'b1, 2'd3, 4'b1000, 4'h0);
    applyStimulus(4'b1101, 4'hF, 1'b1, 8'd0);
    stepChk("t3_ack3", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t3_idle", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);

    // Holdoff of 5: irq low exactly 6 cycles; ack and holdoff changes in HOLD ignored
    applyStimulus(4'b0011, 4'hF, 1'b0, 8'd5);
    stepChk("t4_pend", 1'b0, 1'b0, 2'd0, 4'b0011, 4'h0);
    stepChk("t4_id0", 1'b1, 1'b1, 2'd0, 4'b0011, 4'h0);
    applyStimulus(4'b0011, 4'hF, 1'b1, 8'd5);
    stepChk("t4_low1", 1'b0, 1'b0, 2'd0, 4'b0010, 4'h0);
    applyStimulus(4'b0011, 4'hF, 1'b0, 8'd1);
    stepChk("t4_low2", 1'b0, 1'b0, 2'd0, 4'b0010, 4'h0);
    applyStimulus(4'b0011, 4'hF, 1'b1, 8'd1);
    stepChk("t4_low3_ack", 1'b0, 1'b0, 2'd0, 4'b0010, 4'h0);
    applyStimulus(4'b0011, 4'hF, 1'b0, 8'd1);
    for (int i = 4; i <= 6; i++) begin
      stepChk($sformatf("t4_low%0d", i), 1'b0, 1'b0, 2'd0, 4'b0010, 4'h0);
    end
    stepChk("t4_reraise", 1'b1, 1'b1, 2'd1, 4'b0010, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 8'd1);
    stepChk("t4_ack1", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t4_hold1", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    stepChk("t4_idle", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);

    // Overflow, ack clear, and set/clear on the same cycle
    applyStimulus(4'b0010, 4'hF, 1'b0, 8'd0);
    stepChk("t5_pend", 1'b0, 1'b0, 2'd0, 4'b0010, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t5_irq", 1'b1, 1'b1, 2'd1, 4'b0010, 4'h0);
    applyStimulus(4'b0010, 4'hF, 1'b0, 8'd0);
    stepChk("t5_ovf", 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0010);
    applyStimulus(4'b0000, 4'hF, 1'b1, 8'd0);
    stepChk("t5_ack_clr", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    applyStimulus(4'b0010, 4'hF, 1'b0, 8'd0);
    stepChk("t5_repend", 1'b0, 1'b0, 2'd0, 4'b0010, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t5_irq2", 1'b1, 1'b1, 2'd1, 4'b0010, 4'h0);
    applyStimulus(4'b0010, 4'hF, 1'b1, 8'd0);
    stepChk("t5_set_wins", 1'b0, 1'b0, 2'd0, 4'b0010, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t5_irq3", 1'b1, 1'b1, 2'd1, 4'b0010, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 8'd0);
    stepChk("t5_ack3", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);

    // Enable removal during ASSERT, ack in IDLE ignored
    applyStimulus(4'b0100, 4'hF, 1'b0, 8'd0);
    stepChk("t6_pend", 1'b0, 1'b0, 2'd0, 4'b0100, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t6_irq", 1'b1, 1'b1, 2'd2, 4'b0100, 4'h0);
    applyStimulus(4'b0000, 4'b1011, 1'b0, 8'd0);
    stepChk("t6_en_drop", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t6_idle", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 8'd0);
    stepChk("t6_ack_idle", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t6_ack_idle2", 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);

    // Reset asserted mid-ASSERT with two sources pending and one overflowed
    applyStimulus(4'b0011, 4'hF, 1'b0, 8'd0);
    stepChk("t1_pend", 1'b0, 1'b0, 2'd0, 4'b0011, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    stepChk("t1_irq", 1'b1, 1'b1, 2'd0, 4'b0011, 4'h0);
    applyStimulus(4'b0010, 4'hF, 1'b0, 8'd0);
    stepChk("t1_ovf", 1'b1, 1'b1, 2'd0, 4'b0011, 4'b0010);
    applyStimulus(4'b0000, 4'hF, 1'b0, 8'd0);
    rst_n_i = 1'b0;
    #1;
    pushExp("t1_async_rst", 1'b0, 1'b1, 2'd0, 4'h0, 4'h0);
    checkOutput();
    tick();
    rst_n_i = 1'b1;
    stepChk("t1_after_rst", 1'b0, 1'b1, 2'd0, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
